team_09_flash_reader: RTL and testbench

TEAM_09_FLASH_READER -- requirements
Module: team_09_flash_reader

---
 rtl/team_09_flash_reader.sv | 145 ++++++++++++++
 tb/tb_team_09_flash_reader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/team_09_flash_reader.sv
// SPI NOR flash reader: issues a mode-0 0x03 read with a 24-bit address and
// streams len bytes (0 = 256) out as one-cycle data_valid_o pulses.
module team_09_flash_reader #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic [23:0] addr_i,
  input  logic [7:0]  len_i,
  output logic        busy_o,
  output logic [7:0]  data_o,
  output logic        data_valid_o,
  output logic        done_o,
  output logic        flash_csb_o,
  output logic        flash_clk_o,
  output logic        flash_io0_o,
  input  logic        flash_io1_i
);

  typedef enum logic [2:0] {IDLE, CS_SETUP, CMD, ADDR, DATA, CS_HOLD, DONE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] READ_CMD = 8'h03;

  state_t      state, state_n;
  logic [7:0]  div_cnt, div_cnt_n;
  logic [4:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  bytes_left, bytes_left_n;
  logic [31:0] shreg, shreg_n;
  logic [7:0]  data_n;
  logic        sck_n, mosi_n, csb_n, busy_n, valid_n, done_n;
  logic        half_end;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n      = state;
    div_cnt_n    = div_cnt;
    bit_cnt_n    = bit_cnt;
    bytes_left_n = bytes_left;
    shreg_n      = shreg;
    data_n       = data_o;
    sck_n        = flash_clk_o;
    valid_n      = 1'b0;
    done_n       = 1'b0;
    half_end     = (div_cnt == DIV_LAST);

    if (state != IDLE) div_cnt_n = half_end ? 8'd0 : div_cnt + 8'd1;

    case (state)
      IDLE: begin
        if (start_i) begin
          state_n      = CS_SETUP;
          div_cnt_n    = 8'd0;
          bit_cnt_n    = 5'd0;
          bytes_left_n = len_i;
          shreg_n      = {READ_CMD, addr_i};
        end
      end
      CS_SETUP: if (half_end) state_n = CMD;
      CMD, ADDR, DATA: begin
        if (half_end) begin
          sck_n = ~flash_clk_o;
          if (!flash_clk_o) begin
            // Rising SCK: the flash has held MISO stable for a full low half.
            if (state == DATA) begin
              shreg_n = {shreg[30:0], flash_io1_i};
              if (bit_cnt == 5'd7) begin
                data_n  = {shreg[6:0], flash_io1_i};
                valid_n = 1'b1;
              end
            end
          end else begin
            bit_cnt_n = bit_cnt + 5'd1;
            if (state != DATA) shreg_n = {shreg[30:0], 1'b0};
            case (state)
              CMD: if (bit_cnt == 5'd7) begin
                state_n   = ADDR;
                bit_cnt_n = 5'd0;
              end
              ADDR: if (bit_cnt == 5'd23) begin
                state_n   = DATA;
                bit_cnt_n = 5'd0;
              end
              DATA: if (bit_cnt == 5'd7) begin
                bit_cnt_n    = 5'd0;
                bytes_left_n = bytes_left - 8'd1;
                // len 0 loads 0, which wraps through 255 and yields 256 bytes.
                if (bytes_left == 8'd1) state_n = CS_HOLD;
              end
              default: ;
            endcase
          end
        end
      end
      CS_HOLD: begin
        if (half_end) begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end
      DONE: if (half_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    csb_n  = (state_n == IDLE) || (state_n == DONE);
    busy_n = (state_n != IDLE);
    // MOSI follows the shift register only while sending; shreg_n moves on falling SCK.
    mosi_n = (state_n == CS_SETUP || state_n == CMD || state_n == ADDR) ? shreg_n[31] : 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      div_cnt      <= 8'd0;
      bit_cnt      <= 5'd0;
      bytes_left   <= 8'd0;
      shreg        <= 32'd0;
      data_o       <= 8'd0;
      data_valid_o <= 1'b0;
      done_o       <= 1'b0;
      busy_o       <= 1'b0;
      flash_csb_o  <= 1'b1;
      flash_clk_o  <= 1'b0;
      flash_io0_o  <= 1'b0;
    end else begin
      state        <= state_n;
      div_cnt      <= div_cnt_n;
      bit_cnt      <= bit_cnt_n;
      bytes_left   <= bytes_left_n;
      shreg        <= shreg_n;
      data_o       <= data_n;
      data_valid_o <= valid_n;
      done_o       <= done_n;
      busy_o       <= busy_n;
      flash_csb_o  <= csb_n;
      flash_clk_o  <= sck_n;
      flash_io0_o  <= mosi_n;
    end
  end

endmodule

// File: tb/tb_team_09_flash_reader.sv
// Scoreboard bench for team_09_flash_reader: two DUTs (CLK_DIV 2 and 1), each
// attached to a behavioural SPI flash model serving a fixed byte image.
module tb_team_09_flash_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] addr;
  logic [7:0]  len;
  logic [1:0]  start, busy, dv, done, csb, sck, mosi, miso;
  logic [7:0]  dat [2];

  always #5 clk = ~clk;

  team_09_flash_reader #(.CLK_DIV(2)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start[0]), .addr_i(addr), .len_i(len),
    .busy_o(busy[0]), .data_o(dat[0]), .data_valid_o(dv[0]), .done_o(done[0]),
    .flash_csb_o(csb[0]), .flash_clk_o(sck[0]), .flash_io0_o(mosi[0]), .flash_io1_i(miso[0])
  );

  team_09_flash_reader #(.CLK_DIV(1)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start[1]), .addr_i(addr), .len_i(len),
    .busy_o(busy[1]), .data_o(dat[1]), .data_valid_o(dv[1]), .done_o(done[1]),
    .flash_csb_o(csb[1]), .flash_clk_o(sck[1]), .flash_io0_o(mosi[1]), .flash_io1_i(miso[1])
  );

  logic [7:0]  mem [512];
  logic [7:0]  exp_data [2][$];
  logic [31:0] exp_hdr  [2][$];
  logic [31:0] hdr_got  [2][$];
  int          exp_low  [2][$];
  int          exp_done [2][$];
  int          checks = 0;
  int          errors = 0;

  function automatic int div_of(int l);
    return (l == 0) ? 2 : 1;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Flash model (sampled #1 after each edge) followed by the output monitor.
  int          cnt [2];
  logic [31:0] hdr [2];
  logic [1:0]  sck_p = 2'b00;
  logic [1:0]  csb_p = 2'b11;
  int          low_cnt [2];
  int          hi_cnt [2];
  bit          had_txn [2];

  always begin
    int          off;
    logic [7:0]  b;
    logic [31:0] g;
    int          e;
    @(posedge clk);
    #1;
    for (int l = 0; l < 2; l++) begin
      if (csb_p[l] && !csb[l]) cnt[l] = 0;
      if (!csb[l] && sck[l] && !sck_p[l]) begin
        if (cnt[l] < 32) hdr[l] = {hdr[l][30:0], mosi[l]};
        cnt[l]++;
        if (cnt[l] == 32) hdr_got[l].push_back(hdr[l]);
      end
      if (!csb[l] && !sck[l] && sck_p[l] && cnt[l] >= 32) begin
        off     = cnt[l] - 32;
        b       = mem[9'(int'(hdr[l][8:0]) + off / 8)];
        miso[l] = b[3'(7 - off % 8)];
      end
      sck_p[l] = sck[l];
      csb_p[l] = csb[l];
    end

    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      if (dv[l]) begin
        check("data_expected", 32'(exp_data[l].size() != 0), 1);
        if (exp_data[l].size() != 0) check("data_value", 32'(dat[l]), 32'(exp_data[l].pop_front()));
      end
      if (done[l]) begin
        check("done_expected", 32'(exp_done[l].size() != 0), 1);
        if (exp_done[l].size() != 0) void'(exp_done[l].pop_front());
        check("bytes_before_done", 32'(exp_data[l].size()), 0);
      end
      while (hdr_got[l].size() != 0) begin
        g = hdr_got[l].pop_front();
        check("hdr_expected", 32'(exp_hdr[l].size() != 0), 1);
        if (exp_hdr[l].size() != 0) check("mosi_header", g, exp_hdr[l].pop_front());
      end
      if (!csb[l]) begin
        if (low_cnt[l] == 0 && had_txn[l]) check("csb_high_min", 32'(hi_cnt[l] >= div_of(l)), 1);
        low_cnt[l]++;
        hi_cnt[l] = 0;
      end else begin
        if (low_cnt[l] > 0) begin
          check("csb_low_expected", 32'(exp_low[l].size() != 0), 1);
          if (exp_low[l].size() != 0) begin
            e = exp_low[l].pop_front();
            if (e != 0) check("csb_low_cycles", 32'(low_cnt[l]), 32'(e));
          end
          had_txn[l] = 1'b1;
          low_cnt[l] = 0;
        end
        hi_cnt[l]++;
      end
    end
  end

  // Called at a negedge; pushes expectations then pulses start for one cycle.
  // An aborted transaction expects only an unchecked csb-low window.
  task automatic issue(int l, logic [23:0] a, logic [7:0] n, bit abort);
    int nb;
    nb = (n == 8'd0) ? 256 : int'(n);
    check("busy_at_start", 32'(busy[l]), 0);
    if (!abort) begin
      for (int i = 0; i < nb; i++) exp_data[l].push_back(mem[9'(int'(a[8:0]) + i)]);
      exp_hdr[l].push_back({8'h03, a});
      exp_done[l].push_back(1);
      exp_low[l].push_back(div_of(l) * (2 + 2 * (32 + 8 * nb)));
    end else begin
      exp_low[l].push_back(0);
    end
    addr     = a;
    len      = n;
    start[l] = 1'b1;
    @(negedge clk);
    start[l] = 1'b0;
  endtask

  task automatic wait_idle(int l, int budget);
    int i;
    i = 0;
    while (busy[l] && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("idle_timeout", 32'(busy[l]), 0);
  endtask

  task automatic check_reset_outputs(int l);
    check("rst_csb",   32'(csb[l]),  1);
    check("rst_sck",   32'(sck[l]),  0);
    check("rst_mosi",  32'(mosi[l]), 0);
    check("rst_busy",  32'(busy[l]), 0);
    check("rst_valid", 32'(dv[l]),   0);
    check("rst_done",  32'(done[l]), 0);
    check("rst_data",  32'(dat[l]),  0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i);
    mem[16] = 8'hDE;
    mem[17] = 8'hAD;
    mem[18] = 8'hBE;
    mem[19] = 8'hEF;
    for (int l = 0; l < 2; l++) begin
      cnt[l] = 0; hdr[l] = 0; low_cnt[l] = 0; hi_cnt[l] = 0; had_txn[l] = 1'b0;
    end
    miso  = 2'b00;
    rst   = 1'b1;
    start = 2'b00;
    addr  = 24'd0;
    len   = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs(0);
    check_reset_outputs(1);

    // Four-byte read of DE AD BE EF.
    issue(0, 24'h000010, 8'd4, 1'b0);
    wait_idle(0, 2000);

    // len 0 reads the full 256-byte page.
    issue(0, 24'h000000, 8'd0, 1'b0);
    wait_idle(0, 20000);

    // A start while busy must be ignored.
    issue(0, 24'h000020, 8'd2, 1'b0);
    repeat (20) @(negedge clk);
    check("busy_mid_txn", 32'(busy[0]), 1);
    addr     = 24'h000100;
    len      = 8'd1;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_idle(0, 2000);

    // Reset during the address phase, then a clean one-byte read.
    issue(0, 24'h000010, 8'd4, 1'b1);
    repeat (50) @(negedge clk);
    check("abort_csb_low", 32'(csb[0]), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs(0);
    repeat (5) @(negedge clk);
    issue(0, 24'h000010, 8'd1, 1'b0);
    wait_idle(0, 2000);

    // CLK_DIV=1 single byte.
    issue(1, 24'h000012, 8'd1, 1'b0);
    wait_idle(1, 2000);

    // Back-to-back: second start on the first idle cycle.
    issue(0, 24'h000013, 8'd1, 1'b0);
    wait_idle(0, 2000);
    issue(0, 24'h000011, 8'd2, 1'b0);
    wait_idle(0, 2000);

    repeat (10) @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      check("data_left",  32'(exp_data[l].size()), 0);
      check("hdr_left",   32'(exp_hdr[l].size()),  0);
      check("done_left",  32'(exp_done[l].size()), 0);
      check("low_left",   32'(exp_low[l].size()),  0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
